multdiv_issue_ctrl: RTL and testbench
=====================================

Name: multdiv_issue_ctrl

Overview:
Execute-stage sequencer that sits directly upstream of the ALU's multiply/divide path. It detects a mult/div instruction (opcode 5'd6 or 5'd7) entering execute and freezes its operands and opcode. It issues a one-cycle start to the multdiv unit, stalls the pipeline until the unit signals result-ready, then presents the registered result, exception and destination register to the X/M latch for exactly one cycle. A watchdog counter bounds the wait.

Parameters:
TIMEOUT, 40, maximum WAIT cycles before a forced exception completion.
CNT_W, 6, counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
valid_in  input  1  instruction in execute is valid
opcode_in  input  5  ALU opcode of instruction in execute
operandA_in  input  32  operand A from decode/bypass
operandB_in  input  32  operand B from decode/bypass
rd_in  input  5  destination register
flush  input  1  squash in-flight op (branch mispredict)
md_result  input  32  result from ALU multdiv path
md_exception  input  1  exception flag from multdiv (divide by zero / overflow)
md_ready  input  1  multdiv result-ready
hold_operandA  output  32  latched operand A driven to ALU
hold_operandB  output  32  latched operand B driven to ALU
hold_opcode  output  5  latched opcode driven to ALU (6 or 7, else 0)
md_start_mult  output  1  one-cycle mult start
md_start_div  output  1  one-cycle div start
stall  output  1  freeze PC, F/D and D/X latches
result_valid  output  1  one-cycle completion strobe
result  output  32  registered multdiv result
exception  output  1  registered exception (md_exception OR timeout)
rd_out  output  5  destination register of completed op

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs, holds and counter = 0.
- is_md = valid_in & (opcode_in==6 | opcode_in==7).
- stall (combinational) = (state IDLE & is_md & ~flush) | state==START | state==WAIT. Deasserted in DONE.
- IDLE: if is_md & ~flush, latch A, B, opcode and rd; go to START. Other opcodes are ignored (plain ALU ops bypass this block).
- START, 1 cycle: md_start_mult = (hold_opcode==6); md_start_div = (hold_opcode==7); clear counter; go to WAIT. md_ready in START is ignored (stale).
- WAIT: counter++ each cycle.
  - On md_ready: result<=md_result, exception<=md_exception; go to DONE.
  - Else if counter==TIMEOUT-1: result<=0, exception<=1; go to DONE.
  - md_ready and timeout in the same cycle: md_ready wins.
- DONE, 1 cycle: result_valid=1; result, exception and rd_out stable; go to IDLE. valid_in is ignored in DONE (it is the same held instruction); the next md op is accepted in IDLE the following cycle.
- Minimum latency, detect to result_valid: 3 cycles (IDLE, START, WAIT with immediate ready, DONE strobe in cycle 4).
- flush in START or WAIT: go to IDLE next cycle. No result_valid, no start pulse after the flush cycle, counter cleared. A late md_ready is ignored in IDLE. flush in DONE: result_valid still asserted; the downstream latch decides.
- hold_* remain at the last latched values until the next accept. They are 0 after reset.
- result, exception and rd_out hold their values after DONE until the next completion; consumers qualify them with result_valid.
- Reset mid-operation returns to IDLE. The multdiv unit is not reset by this block; the next start pulse restarts it.
- At most one md op is in flight; no queuing.

Decomposition:
- Shared package/defines file: opcode constants OP_MULT=5'd6, OP_DIV=5'd7; state encoding IDLE=2'd0, START=2'd1, WAIT=2'd2, DONE=2'd3.
- One natural sub-module: md_watchdog (CNT_W counter with clear, enable and terminal-count output at TIMEOUT-1). Everything else stays in the top FSM.

Test Plan:
- Mult 7*6, md_ready 5 cycles after start -> start_mult pulses once; stall high from detect through WAIT; result_valid one cycle with result=42, exception=0, rd_out=rd_in.
- Div 100/0, md_ready with md_exception=1 -> exception=1, result_valid pulse, start_div pulse only, start_mult never.
- md_ready never asserted, TIMEOUT=40 -> result_valid exactly 40 WAIT cycles after START; result=0, exception=1.
- flush two cycles into WAIT, then md_ready -> no result_valid, stall drops the cycle after flush, state IDLE.
- md_ready asserted during the START cycle and again 3 cycles later -> completion on the later ready only.
- reset pulled low during WAIT -> all outputs 0 asynchronously; a new mult 3*3 after release completes with 9.

Source files
------------

// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared definitions for the execute-stage multiply/divide issue controller.
//   OP_MULT / OP_DIV : ALU opcodes routed to the multdiv path
//   md_state_e       : sequencer state encoding (IDLE, START, WAIT, DONE)
package multdiv_issue_ctrl_pkg;

   localparam logic [4:0] OP_MULT = 5'd6;
   localparam logic [4:0] OP_DIV  = 5'd7;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } md_state_e;

   // True for the two opcodes this block sequences.
   function automatic logic is_md_op(input logic [4:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_md_watchdog.sv
// Watchdog counter bounding the wait for the multdiv result.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   clr_i  : synchronous clear (has priority over en_i)
//   en_i   : count up by one this cycle
//   tc_o   : terminal count, high while the count equals TIMEOUT-1
// CNT_W must be wide enough that TIMEOUT-1 is representable.
module md_watchdog #(
   parameter int TIMEOUT = 40,
   parameter int CNT_W   = 6
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear wins over increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (en_i) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= {CNT_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Execute-stage sequencer for the ALU multiply/divide path.
// Captures a mult/div instruction, pulses a one-cycle start, stalls the
// pipeline until the unit reports ready (or the watchdog expires), then
// presents result/exception/rd for one cycle with result_valid.
//   clock, reset            : rising-edge clock, async active-low reset
//   valid_in, opcode_in,
//   operandA_in/B_in, rd_in : instruction currently in execute
//   flush                   : squash the in-flight op
//   md_result/exception/ready : multdiv unit response
//   hold_operandA/B, hold_opcode : frozen operands/opcode to the ALU
//   md_start_mult/div       : one-cycle start pulses
//   stall                   : freeze PC, F/D and D/X
//   result_valid, result, exception, rd_out : completion to X/M latch
module multdiv_issue_ctrl
   import multdiv_issue_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 40,
   parameter int CNT_W   = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [4:0]  opcode_in,
   input  logic [31:0] operandA_in,
   input  logic [31:0] operandB_in,
   input  logic [4:0]  rd_in,
   input  logic        flush,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_ready,
   output logic [31:0] hold_operandA,
   output logic [31:0] hold_operandB,
   output logic [4:0]  hold_opcode,
   output logic        md_start_mult,
   output logic        md_start_div,
   output logic        stall,
   output logic        result_valid,
   output logic [31:0] result,
   output logic        exception,
   output logic [4:0]  rd_out
);

   md_state_e   state_q;
   md_state_e   state_d;

   logic [31:0] hold_a_q;
   logic [31:0] hold_b_q;
   logic [4:0]  hold_op_q;
   logic [4:0]  hold_rd_q;
   logic        start_mult_q;
   logic        start_div_q;
   logic        result_valid_q;
   logic [31:0] result_q;
   logic        exception_q;
   logic [4:0]  rd_out_q;

   logic        accept_s;
   logic        complete_s;
   logic        wd_clr_s;
   logic        wd_en_s;
   logic        wd_tc_s;

   assign accept_s   = (state_q == S_IDLE) && valid_in && is_md_op(opcode_in) && !flush;
   // A flush in WAIT squashes the op even if ready arrives in the same cycle.
   assign complete_s = (state_q == S_WAIT) && !flush && (md_ready || wd_tc_s);

   // The counter only runs in WAIT; any other state or a flush clears it.
   assign wd_en_s  = (state_q == S_WAIT);
   assign wd_clr_s = (state_q != S_WAIT) || flush;

   md_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_watchdog (
      .clk_i  (clock),
      .rst_ni (reset),
      .clr_i  (wd_clr_s),
      .en_i   (wd_en_s),
      .tc_o   (wd_tc_s)
   );

   // Next-state logic. Ready seen in START is stale and deliberately ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) state_d = S_START;
            else          state_d = S_IDLE;
         end
         S_START: begin
            if (flush) state_d = S_IDLE;
            else       state_d = S_WAIT;
         end
         S_WAIT: begin
            if (flush)           state_d = S_IDLE;
            else if (complete_s) state_d = S_DONE;
            else                 state_d = S_WAIT;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand/opcode/rd capture; start pulses are registered so they
   // coincide exactly with the START cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hold_a_q     <= 32'd0;
         hold_b_q     <= 32'd0;
         hold_op_q    <= 5'd0;
         hold_rd_q    <= 5'd0;
         start_mult_q <= 1'b0;
         start_div_q  <= 1'b0;
      end else begin
         start_mult_q <= accept_s && (opcode_in == OP_MULT);
         start_div_q  <= accept_s && (opcode_in == OP_DIV);
         if (accept_s) begin
            hold_a_q  <= operandA_in;
            hold_b_q  <= operandB_in;
            hold_op_q <= opcode_in;
            hold_rd_q <= rd_in;
         end
      end
   end

   // Completion registers; a watchdog expiry reports result 0 with exception.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         result_valid_q <= 1'b0;
         result_q       <= 32'd0;
         exception_q    <= 1'b0;
         rd_out_q       <= 5'd0;
      end else begin
         result_valid_q <= complete_s;
         if (complete_s) begin
            result_q    <= md_ready ? md_result : 32'd0;
            exception_q <= md_ready ? md_exception : 1'b1;
            rd_out_q    <= hold_rd_q;
         end
      end
   end

   assign stall         = accept_s || (state_q == S_START) || (state_q == S_WAIT);
   assign hold_operandA = hold_a_q;
   assign hold_operandB = hold_b_q;
   assign hold_opcode   = hold_op_q;
   assign md_start_mult = start_mult_q;
   assign md_start_div  = start_div_q;
   assign result_valid  = result_valid_q;
   assign result        = result_q;
   assign exception     = exception_q;
   assign rd_out        = rd_out_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
module tb_multdiv_issue_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [4:0]  opcode_in;
   logic [31:0] operandA_in;
   logic [31:0] operandB_in;
   logic [4:0]  rd_in;
   logic        flush;
   logic [31:0] md_result;
   logic        md_exception;
   logic        md_ready;
   logic [31:0] hold_operandA;
   logic [31:0] hold_operandB;
   logic [4:0]  hold_opcode;
   logic        md_start_mult;
   logic        md_start_div;
   logic        stall;
   logic        result_valid;
   logic [31:0] result;
   logic        exception;
   logic [4:0]  rd_out;

   int errors = 0;
   int checks = 0;

   multdiv_issue_ctrl #(.TIMEOUT(40), .CNT_W(6)) dut (
      .clock         (clock),
      .reset         (reset),
      .valid_in      (valid_in),
      .opcode_in     (opcode_in),
      .operandA_in   (operandA_in),
      .operandB_in   (operandB_in),
      .rd_in         (rd_in),
      .flush         (flush),
      .md_result     (md_result),
      .md_exception  (md_exception),
      .md_ready      (md_ready),
      .hold_operandA (hold_operandA),
      .hold_operandB (hold_operandB),
      .hold_opcode   (hold_opcode),
      .md_start_mult (md_start_mult),
      .md_start_div  (md_start_div),
      .stall         (stall),
      .result_valid  (result_valid),
      .result        (result),
      .exception     (exception),
      .rd_out        (rd_out)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      valid_in    = 1'b1;
      opcode_in   = op;
      operandA_in = a;
      operandB_in = b;
      rd_in       = rd;
      #1;
   endtask

   task automatic idle_inputs();
      valid_in  = 1'b0;
      opcode_in = 5'd0;
   endtask

   initial begin
      reset = 1'b0; valid_in = 1'b0; opcode_in = 5'd0; operandA_in = 32'd0;
      operandB_in = 32'd0; rd_in = 5'd0; flush = 1'b0; md_result = 32'd0;
      md_exception = 1'b0; md_ready = 1'b0;

      // ---- reset state
      #12;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_rv", 32'(result_valid), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_holdA", hold_operandA, 32'd0);
      chk("rst_holdop", 32'(hold_opcode), 32'd0);
      reset = 1'b1;
      cyc();

      // ---- plain ALU op is ignored
      issue(5'd2, 32'd1, 32'd2, 5'd1);
      chk("alu_stall", 32'(stall), 32'd0);
      cyc();
      idle_inputs();
      chk("alu_nostart", 32'(md_start_mult), 32'd0);
      chk("alu_holdop", 32'(hold_opcode), 32'd0);

      // ---- md op with flush in IDLE: not accepted, no stall
      issue(5'd6, 32'd9, 32'd9, 5'd1);
      flush = 1'b1; #1;
      chk("iflush_stall", 32'(stall), 32'd0);
      cyc();
      idle_inputs(); flush = 1'b0; #1;
      chk("iflush_nostart", 32'(md_start_mult), 32'd0);
      chk("iflush_holdop", 32'(hold_opcode), 32'd0);

      // ---- mult 7*6, ready 5 cycles after start
      issue(5'd6, 32'd7, 32'd6, 5'd5);
      chk("m_detect_stall", 32'(stall), 32'd1);
      chk("m_detect_nostart", 32'(md_start_mult), 32'd0);
      cyc();
      idle_inputs(); #1;
      chk("m_start_mult", 32'(md_start_mult), 32'd1);
      chk("m_start_div", 32'(md_start_div), 32'd0);
      chk("m_start_stall", 32'(stall), 32'd1);
      chk("m_holdA", hold_operandA, 32'd7);
      chk("m_holdB", hold_operandB, 32'd6);
      chk("m_holdop", 32'(hold_opcode), 32'd6);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("m_wait_stall", 32'(stall), 32'd1);
         chk("m_wait_pulse", 32'(md_start_mult), 32'd0);
         chk("m_wait_rv", 32'(result_valid), 32'd0);
      end
      cyc();
      md_ready = 1'b1; md_result = 32'd42; md_exception = 1'b0; #1;
      chk("m_ready_stall", 32'(stall), 32'd1);
      cyc();
      md_ready = 1'b0; md_result = 32'd0; #1;
      chk("m_done_rv", 32'(result_valid), 32'd1);
      chk("m_done_result", result, 32'd42);
      chk("m_done_exc", 32'(exception), 32'd0);
      chk("m_done_rd", 32'(rd_out), 32'd5);
      chk("m_done_stall", 32'(stall), 32'd0);
      cyc();
      chk("m_after_rv", 32'(result_valid), 32'd0);
      chk("m_after_result", result, 32'd42);

      // ---- div 100/0 with exception
      issue(5'd7, 32'd100, 32'd0, 5'd9);
      cyc();
      idle_inputs(); #1;
      chk("d_start_div", 32'(md_start_div), 32'd1);
      chk("d_start_mult", 32'(md_start_mult), 32'd0);
      chk("d_holdop", 32'(hold_opcode), 32'd7);
      cyc();
      chk("d_wait_mult", 32'(md_start_mult), 32'd0);
      md_ready = 1'b1; md_exception = 1'b1; md_result = 32'd0; #1;
      cyc();
      md_ready = 1'b0; md_exception = 1'b0; #1;
      chk("d_done_rv", 32'(result_valid), 32'd1);
      chk("d_done_exc", 32'(exception), 32'd1);
      chk("d_done_rd", 32'(rd_out), 32'd9);
      chk("d_done_mult", 32'(md_start_mult), 32'd0);
      cyc();

      // ---- timeout: no ready, DONE after 40 WAIT cycles
      issue(5'd6, 32'd1, 32'd2, 5'd3);
      cyc();
      idle_inputs(); #1;
      chk("t_start", 32'(md_start_mult), 32'd1);
      for (int i = 0; i < 40; i++) begin
         cyc();
         chk("t_wait_rv", 32'(result_valid), 32'd0);
         chk("t_wait_stall", 32'(stall), 32'd1);
      end
      cyc();
      chk("t_done_rv", 32'(result_valid), 32'd1);
      chk("t_done_result", result, 32'd0);
      chk("t_done_exc", 32'(exception), 32'd1);
      chk("t_done_rd", 32'(rd_out), 32'd3);
      cyc();

      // ---- flush two cycles into WAIT, then a late ready
      issue(5'd6, 32'd4, 32'd5, 5'd4);
      cyc();
      idle_inputs(); #1;
      cyc();
      cyc();
      flush = 1'b1; #1;
      chk("f_flush_stall", 32'(stall), 32'd1);
      cyc();
      flush = 1'b0; md_ready = 1'b1; md_result = 32'd20; #1;
      chk("f_idle_stall", 32'(stall), 32'd0);
      chk("f_idle_rv", 32'(result_valid), 32'd0);
      cyc();
      md_ready = 1'b0; #1;
      chk("f_late_rv", 32'(result_valid), 32'd0);
      chk("f_late_result", result, 32'd0);
      chk("f_late_pulse", 32'(md_start_mult), 32'd0);
      cyc();
      chk("f_late_rv2", 32'(result_valid), 32'd0);

      // ---- stale ready in START ignored; completion on the later ready
      issue(5'd7, 32'd8, 32'd2, 5'd7);
      cyc();
      idle_inputs();
      md_ready = 1'b1; md_result = 32'd111; #1;
      chk("s_start_div", 32'(md_start_div), 32'd1);
      cyc();
      md_ready = 1'b0; #1;
      chk("s_wait1_rv", 32'(result_valid), 32'd0);
      cyc();
      chk("s_wait2_rv", 32'(result_valid), 32'd0);
      chk("s_wait2_stall", 32'(stall), 32'd1);
      cyc();
      md_ready = 1'b1; md_result = 32'd222; #1;
      cyc();
      md_ready = 1'b0; #1;
      chk("s_done_rv", 32'(result_valid), 32'd1);
      chk("s_done_result", result, 32'd222);
      chk("s_done_rd", 32'(rd_out), 32'd7);
      cyc();

      // ---- asynchronous reset during WAIT
      issue(5'd6, 32'd11, 32'd13, 5'd2);
      cyc();
      idle_inputs(); #1;
      cyc();
      #2;
      reset = 1'b0; #1;
      chk("r_stall", 32'(stall), 32'd0);
      chk("r_result", result, 32'd0);
      chk("r_rd", 32'(rd_out), 32'd0);
      chk("r_holdA", hold_operandA, 32'd0);
      chk("r_holdB", hold_operandB, 32'd0);
      chk("r_holdop", 32'(hold_opcode), 32'd0);
      cyc();
      reset = 1'b1;
      cyc();

      // ---- mult 3*3 after reset, minimum latency
      issue(5'd6, 32'd3, 32'd3, 5'd1);
      cyc();
      idle_inputs(); #1;
      chk("n_start", 32'(md_start_mult), 32'd1);
      chk("n_holdA", hold_operandA, 32'd3);
      cyc();
      md_ready = 1'b1; md_result = 32'd9; #1;
      cyc();
      md_ready = 1'b0; #1;
      chk("n_done_rv", 32'(result_valid), 32'd1);
      chk("n_done_result", result, 32'd9);
      chk("n_done_exc", 32'(exception), 32'd0);
      chk("n_done_rd", 32'(rd_out), 32'd1);
      cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
